mem_port_arbiter: RTL and testbench

// Shares one single-ported instruction/data memory between the fetch stage and the

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the fetch
// stage and the memory stage. One fixed-latency access at a time. Data requests
// have priority, but a fetch that has waited STARVE_MAX data grants is forced through.
// Optional feature macro: ARB_PERF_EN adds saturating performance counters
// (perf_fetch_wait, perf_data_grants).
module mem_port_arbiter #(
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0] perf_fetch_wait,
    output logic [31:0] perf_data_grants
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] LAT_L    = 4'(LATENCY);
    localparam logic [7:0] STARVE_L = 8'(STARVE_MAX);

    state_t      state_r;
    logic [3:0]  lat_r;
    logic [7:0]  starve_r;
    logic        grant_i_s;
    logic        grant_d_s;

    // Grant decision: only in IDLE; data wins unless fetch has been starved.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_r == IDLE) begin
            if (if_req && (!d_req || (starve_r == STARVE_L))) begin
                grant_i_s = 1'b1;
            end else if (d_req) begin
                grant_d_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
                grant_d_s = 1'b0;
            end
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Arbitration FSM: issues the memory strobe, counts latency, captures read data
    // and pulses the ready of the requester that owned the transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            lat_r     <= 4'd0;
            starve_r  <= 8'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_i_s) begin
                        state_r   <= BUSY_I;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= 32'd0;
                        lat_r     <= LAT_L;
                        starve_r  <= 8'd0;
                    end else if (grant_d_s) begin
                        state_r   <= BUSY_D;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        lat_r     <= LAT_L;
                        starve_r  <= if_req ? (starve_r + 8'd1) : 8'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I: begin
                    // lat_r reaches 0 in the cycle mem_rdata is valid
                    if (lat_r == 4'd0) begin
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        lat_r <= lat_r - 4'd1;
                    end
                end
                BUSY_D: begin
                    if (lat_r == 4'd0) begin
                        // stores complete with a ready pulse but leave load data alone
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end else begin
                            d_rdata <= d_rdata;
                        end
                        d_ready <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        lat_r <= lat_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_EN
    // Saturating counters: fetch wait cycles and data grants.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_wait  <= 32'd0;
            perf_data_grants <= 32'd0;
        end else begin
            if (if_req && (state_r != BUSY_I) && !grant_i_s &&
                (perf_fetch_wait != 32'hFFFF_FFFF)) begin
                perf_fetch_wait <= perf_fetch_wait + 32'd1;
            end else begin
                perf_fetch_wait <= perf_fetch_wait;
            end
            if (grant_d_s && (perf_data_grants != 32'hFFFF_FFFF)) begin
                perf_data_grants <= perf_data_grants + 32'd1;
            end else begin
                perf_data_grants <= perf_data_grants;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (LATENCY=2, STARVE_MAX=4).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] rd_pipe;
`ifdef ARB_PERF_EN
    logic [31:0] perf_fetch_wait;
    logic [31:0] perf_data_grants;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LATENCY(2), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_PERF_EN
        ,
        .perf_fetch_wait  (perf_fetch_wait),
        .perf_data_grants (perf_data_grants)
`endif
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0) return 32'h2002_0005;
        return {a[15:0], 16'hC0DE} ^ 32'h1357_2468;
    endfunction

    // Memory model: read data valid exactly two cycles after the strobe, garbage otherwise.
    always @(posedge clk) begin
        rd_pipe   <= mem_en ? mem_val(mem_addr) : 32'hDEAD_DEAD;
        mem_rdata <= rd_pipe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        int          waited;

        reset = 1'b0; if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_mem_en",   32'(mem_en),   32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_d_ready",  32'(d_ready),  32'd0);
        chk("rst_mem_addr", mem_addr,      32'd0);
        chk("rst_if_rdata", if_rdata,      32'd0);
        chk("rst_d_rdata",  d_rdata,       32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_mem_en", 32'(mem_en), 32'd0);

        // Test 1: single fetch
        if_req = 1'b1; if_addr = 32'h0;
        @(negedge clk);
        chk("t1_mem_en",   32'(mem_en), 32'd1);
        chk("t1_mem_addr", mem_addr,    32'h0);
        chk("t1_mem_we",   32'(mem_we), 32'd0);
        @(negedge clk);
        chk("t1_early_rdy", 32'(if_ready), 32'd0);
        chk("t1_busy_en",   32'(mem_en),   32'd0);
        @(negedge clk);
        chk("t1_early_rdy2", 32'(if_ready), 32'd0);
        @(negedge clk);
        chk("t1_if_ready", 32'(if_ready), 32'd1);
        chk("t1_if_rdata", if_rdata,      32'h2002_0005);
        chk("t1_d_ready",  32'(d_ready),  32'd0);
        if_req = 1'b0;
        @(negedge clk);
        chk("t1_rdy_off",    32'(if_ready), 32'd0);
        chk("t1_no_regrant", 32'(mem_en),   32'd0);

        // Test 2: simultaneous requests, data first
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        @(negedge clk);
        chk("t2_d_en",   32'(mem_en), 32'd1);
        chk("t2_d_addr", mem_addr,    32'h200);
        @(negedge clk);
        chk("t2_busy_en1", 32'(mem_en), 32'd0);
        @(negedge clk);
        chk("t2_busy_en2", 32'(mem_en), 32'd0);
        @(negedge clk);
        chk("t2_d_ready",  32'(d_ready),  32'd1);
        chk("t2_d_rdata",  d_rdata,       mem_val(32'h200));
        chk("t2_if_ready", 32'(if_ready), 32'd0);
        chk("t2_rdy_en",   32'(mem_en),   32'd0);
        d_req = 1'b0;
        @(negedge clk);
        chk("t2_i_en",   32'(mem_en), 32'd1);
        chk("t2_i_addr", mem_addr,    32'h100);
        repeat (3) @(negedge clk);
        chk("t2_if_ready", 32'(if_ready), 32'd1);
        chk("t2_if_rdata", if_rdata,      mem_val(32'h100));
        chk("t2_d_quiet",  32'(d_ready),  32'd0);
        if_req = 1'b0;

        // Clean start for the starvation test (also clears performance counters)
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        // Test 3: starvation, expected grant order D D D D F D
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        for (int k = 0; k < 6; k++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!mem_en && waited < 10);
            chk($sformatf("t3_gap%0d", k),  32'(waited), 32'd1);
            chk($sformatf("t3_en%0d", k),   32'(mem_en), 32'd1);
            chk($sformatf("t3_addr%0d", k), mem_addr, (k == 4) ? 32'h300 : 32'h400);
            repeat (3) @(negedge clk);
            if (k == 4) begin
                chk("t3_if_ready", 32'(if_ready), 32'd1);
                chk("t3_if_rdata", if_rdata,      mem_val(32'h300));
                if_req = 1'b0;
            end else begin
                chk($sformatf("t3_d_ready%0d", k), 32'(d_ready), 32'd1);
                if (k == 5) d_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("t3_idle_en", 32'(mem_en), 32'd0);
`ifdef ARB_PERF_EN
        // Data grants: four before the forced fetch plus one after.
        chk("t6_perf_data_grants", perf_data_grants, 32'd5);
        // Fetch pending edges: request cycle (1) + D1..D3 (4 each) + D4 up to the
        // fetch grant (3) = 16.
        chk("t6_perf_fetch_wait", perf_fetch_wait, 32'd16);
`endif

        // Test 4: store leaves load data untouched
        prev = mem_val(32'h400);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'd7;
        @(negedge clk);
        chk("t4_mem_en",    32'(mem_en), 32'd1);
        chk("t4_mem_we",    32'(mem_we), 32'd1);
        chk("t4_mem_addr",  mem_addr,    32'h54);
        chk("t4_mem_wdata", mem_wdata,   32'd7);
        repeat (3) @(negedge clk);
        chk("t4_d_ready", 32'(d_ready), 32'd1);
        chk("t4_d_rdata", d_rdata,      prev);
        d_req = 1'b0; d_we = 1'b0;

        // Test 5: reset aborts a transaction, request re-granted after release
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h500;
        @(negedge clk);
        chk("t5_mem_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_rst_en",     32'(mem_en),   32'd0);
        chk("t5_rst_addr",   mem_addr,      32'd0);
        chk("t5_rst_ifdata", if_rdata,      32'd0);
        chk("t5_rst_ddata",  d_rdata,       32'd0);
        chk("t5_rst_ready",  32'(if_ready), 32'd0);
`ifdef ARB_PERF_EN
        chk("t5_rst_perf", perf_data_grants, 32'd0);
`endif
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_ready", 32'(if_ready), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("t5_regrant_en",   32'(mem_en), 32'd1);
        chk("t5_regrant_addr", mem_addr,    32'h500);
        repeat (3) @(negedge clk);
        chk("t5_if_ready", 32'(if_ready), 32'd1);
        chk("t5_if_rdata", if_rdata,      mem_val(32'h500));
        if_req = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
